// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit 2-flop synchroniser plus stability counter for a
// bank of raw switch inputs. A new level is accepted only after it has been
// seen on the synchronised input for STABLE_CYCLES consecutive cycles. Each
// acceptance emits a one-cycle rise/fall pulse and an aggregate change strobe.
// Every output comes straight from a flop, so there is no combinational path
// from sw_in to any output.

module switch_debouncer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] rose,
    output logic [WIDTH-1:0] fell,
    output logic             changed
);

    // Terminal count: a mismatch seen while the counter holds this value is
    // the STABLE_CYCLES-th consecutive one, so the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser stages
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    // Per-bit stability counters
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Debounced level and event pulses
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic [WIDTH-1:0] rose_q, rose_d;
    logic [WIDTH-1:0] fell_q, fell_d;
    logic             changed_q, changed_d;

    // Two-stage synchroniser; only sync2 feeds the debounce logic
    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: clear on match, count on mismatch, accept at terminal count
    always_comb begin
        d_out_d = d_out_q;
        cnt_d   = cnt_q;
        rose_d  = '0;
        fell_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == d_out_q[i]) begin
                // Level agrees with the accepted value: any partial count is a glitch
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_LAST) begin
                // Held long enough: accept and restart so the next event needs a full run
                d_out_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rose_d[i]  = sync2_q[i];
                fell_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Aggregate strobe lines up with the rose/fell pulses it summarises
    always_comb begin
        changed_d = |(rose_d | fell_d);
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            d_out_q   <= '0;
            rose_q    <= '0;
            fell_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            d_out_q   <= d_out_d;
            rose_q    <= rose_d;
            fell_q    <= fell_d;
            changed_q <= changed_d;
        end
    end

    // Outputs are taken directly from flops
    assign d_out   = d_out_q;
    assign rose    = rose_q;
    assign fell    = fell_q;
    assign changed = changed_q;

endmodule
